timer_ctrl_fsm: RTL and testbench
=================================

Name: timer_ctrl_fsm

Overview:
- Button-driven control sequencer for the countdown timer block.
- Converts four user button levels into one-cycle start/stop/reset/inc_min/inc_sec command pulses for the timer.
- Tracks the user-visible mode (IDLE/SET/RUN/PAUSE/ALARM) from the timer's minutes/seconds/blink outputs.
- Provides press-and-hold auto-repeat for time entry and a bounded alarm duration.
- Sits between the debounced board buttons and the timer instance.

Parameters:
- REPEAT_DELAY_MS, 500, tick_1k strobes a min/sec button must be held before auto-repeat begins.
- REPEAT_RATE_MS, 100, tick_1k strobes between auto-repeat pulses once repeating.
- ALARM_TIMEOUT_MS, 30000, tick_1k strobes spent in ALARM before automatic clear.

Ports:
- clk  input  1  system clock (100 MHz).
- rst_n  input  1  asynchronous active-low reset.
- tick_1k  input  1  one-clk-wide 1 kHz enable strobe in the clk domain.
- btn_start_stop  input  1  debounced, synchronized button level.
- btn_reset  input  1  debounced, synchronized button level.
- btn_min  input  1  debounced, synchronized button level.
- btn_sec  input  1  debounced, synchronized button level.
- minutes  input  6  timer minutes value.
- seconds  input  6  timer seconds value.
- blink  input  1  timer expiry indicator.
- en  output  1  timer enable.
- start  output  1  one-cycle start pulse to timer.
- stop  output  1  one-cycle stop pulse to timer.
- reset  output  1  one-cycle clear pulse to timer.
- inc_min  output  1  one-cycle minute-increment pulse.
- inc_sec  output  1  one-cycle second-increment pulse.
- alarm  output  1  high while in ALARM.
- state  output  3  current ctrl_state_t for display logic.

Behaviour:
- Single clock, clk. rst_n is asynchronous, active-low.
- Reset values: all outputs 0, state=IDLE, all counters 0.
- Button edge-detect history registers reset to 1, so a button held through reset release is not treated as a press.
- en is registered: 0 during reset, 1 from the first clk edge after release.
- Press definition: level 1 at cycle N with level 0 at N-1.
- Command pulse timing: the pulse is high at cycle N+1 for exactly one cycle. All command outputs are registered.
- At most one command per cycle. Priority for simultaneous presses: reset > start_stop > min > sec. Lower-priority presses in that cycle are dropped.
- Auto-repeat (btn_min/btn_sec, only in IDLE/SET/PAUSE):
  - While held, count tick_1k strobes.
  - The first repeat pulse is issued at count REPEAT_DELAY_MS.
  - Further repeat pulses follow every REPEAT_RATE_MS ticks.
  - Release clears the counter.
  - If both buttons are held, only btn_min repeats.
  - Counter width is $clog2(max(REPEAT_DELAY_MS, REPEAT_RATE_MS)+1); it saturates and never wraps.
- time_zero = (minutes==0 && seconds==0).
- State transitions (the state update is coincident with the issued pulse):
  - IDLE:
    - min/sec press → inc pulse, go to SET.
    - start_stop press → ignored.
    - reset press → reset pulse, stay in IDLE.
  - SET:
    - min/sec press or repeat → inc pulse.
    - start_stop press with !time_zero → start pulse, go to RUN.
    - start_stop press with time_zero → ignored.
    - reset press → reset pulse, go to IDLE.
  - RUN:
    - start_stop press → stop pulse, go to PAUSE.
    - min/sec presses are ignored, and repeat counters are held at 0.
    - blink==1 or time_zero sampled → go to ALARM (no pulse).
    - reset press → reset pulse, go to IDLE.
  - PAUSE:
    - start_stop press → start pulse, go to RUN.
    - min/sec press → inc pulse, go to SET.
    - reset press → reset pulse, go to IDLE.
  - ALARM:
    - alarm=1.
    - Any button press, or the timeout counter reaching ALARM_TIMEOUT_MS → reset pulse, go to IDLE. A button press does not also issue its own command.
    - The timeout counter clears on ALARM entry. Width is $clog2(ALARM_TIMEOUT_MS+1).
- If rst_n is asserted mid-operation (e.g. during RUN or ALARM), outputs immediately go to their reset values. No stop or reset pulse is emitted.
- tick_1k is ignored outside the repeat and alarm counters.

Decomposition:
- Package timer_ctrl_pkg contains:
  - typedef enum logic [2:0] ctrl_state_t {IDLE=0, SET=1, RUN=2, PAUSE=3, ALARM=4}.
  - typedef enum logic [2:0] ctrl_cmd_t {CMD_NONE, CMD_START, CMD_STOP, CMD_RESET, CMD_MIN, CMD_SEC}.
- Sub-module btn_repeat (params DELAY, RATE):
  - Does edge detection plus the hold counter.
  - Outputs press_pulse and repeat_pulse.
  - Instantiated for btn_min and btn_sec.
- start_stop and reset use inline edge detection.

Test Plan:
- Reset hygiene: hold btn_min=1 through rst_n release → no inc_min pulse; state=IDLE, en=1 one cycle after release.
- Set-and-run: 3 btn_sec presses, then btn_start_stop → exactly 3 inc_sec pulses, then 1 start pulse; state SET→RUN; timer reads 0:03.
- Pause/resume: in RUN, press start_stop → stop pulse, state=PAUSE; press again → start pulse, state=RUN.
- Auto-repeat: tick_1k every 10 clk, REPEAT_DELAY_MS=5, REPEAT_RATE_MS=2; hold btn_min for 11 ticks → 1 press pulse + repeats at ticks 5, 7, 9, 11 (5 inc_min total).
- Priority: btn_reset and btn_start_stop rise in the same cycle in RUN → only the reset pulse; state=IDLE.
- Alarm: timer expires (blink=1) → alarm=1, state=ALARM; with ALARM_TIMEOUT_MS=20 and no buttons, reset pulse after 20 ticks, alarm=0; repeat with a btn_sec press at tick 3 → reset pulse (no inc_sec), state=IDLE.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// Shared types for the countdown-timer control sequencer.
//   ctrl_state_t : user-visible mode, also driven out on the 'state' port
//   ctrl_cmd_t   : the single command chosen in a cycle (at most one)
package timer_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    ALARM = 3'd4
  } ctrl_state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_START,
    CMD_STOP,
    CMD_RESET,
    CMD_MIN,
    CMD_SEC
  } ctrl_cmd_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Edge detector plus press-and-hold auto-repeat for one button.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   btn_i         : debounced button level
//   tick_i        : 1 kHz enable strobe
//   rep_en_i      : repeat counting allowed (counter held at 0 when low)
//   press_o       : combinational, high in the cycle the level first reads 1
//   repeat_o      : combinational, high in the cycle a repeat falls due
module btn_repeat
  import timer_ctrl_pkg::*;
#(
  parameter int DELAY = 500,
  parameter int RATE  = 100
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  input  logic tick_i,
  input  logic rep_en_i,
  output logic press_o,
  output logic repeat_o
);

  localparam int CW = $clog2(max_int(DELAY, RATE) + 1);

  logic          btn_q;
  logic          armed_q, armed_d;
  logic          rate_phase_q, rate_phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed;
  int            target;

  // History resets to 1: a level already high at reset release is no press.
  assign press_o = btn_i & ~btn_q;
  // Only a hold that began with a real press may auto-repeat.
  assign armed   = armed_q | press_o;
  assign target  = rate_phase_q ? RATE : DELAY;

  always_comb begin
    armed_d      = armed_q;
    rate_phase_d = rate_phase_q;
    cnt_d        = cnt_q;
    repeat_o     = 1'b0;
    if (!btn_i) begin
      armed_d      = 1'b0;
      rate_phase_d = 1'b0;
      cnt_d        = '0;
    end else begin
      armed_d = armed;
      if (!rep_en_i) begin
        rate_phase_d = 1'b0;
        cnt_d        = '0;
      end else if (armed && tick_i) begin
        // Count restarts at each repeat, so it never passes its target.
        if (int'(cnt_q) + 1 >= target) begin
          repeat_o     = 1'b1;
          rate_phase_d = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_q        <= 1'b1;
      armed_q      <= 1'b0;
      rate_phase_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      btn_q        <= btn_i;
      armed_q      <= armed_d;
      rate_phase_q <= rate_phase_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_ctrl_fsm.sv
// Button-driven control sequencer for the countdown timer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   tick_1k             : 1 kHz strobe (repeat and alarm counters only)
//   btn_*               : debounced button levels
//   minutes/seconds     : timer value; blink : timer expired
//   en                  : timer enable (1 from first edge after reset)
//   start/stop/reset/inc_min/inc_sec : registered one-cycle commands
//   alarm               : high while in ALARM; state : current ctrl_state_t
// A press at cycle N yields its command at N+1, together with the new state.
module timer_ctrl_fsm
  import timer_ctrl_pkg::*;
#(
  parameter int REPEAT_DELAY_MS  = 500,
  parameter int REPEAT_RATE_MS   = 100,
  parameter int ALARM_TIMEOUT_MS = 30000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1k,
  input  logic       btn_start_stop,
  input  logic       btn_reset,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       blink,
  output logic       en,
  output logic       start,
  output logic       stop,
  output logic       reset,
  output logic       inc_min,
  output logic       inc_sec,
  output logic       alarm,
  output logic [2:0] state
);

  localparam int AW = $clog2(ALARM_TIMEOUT_MS + 1);

  ctrl_state_t   state_q, state_d;
  ctrl_cmd_t     cmd_d;
  logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
  logic          ss_q, rs_q;
  logic          en_q, start_q, stop_q, reset_q, inc_min_q, inc_sec_q, alarm_q;
  logic          ss_press, rs_press, min_press, sec_press, min_rep, sec_rep;
  logic          min_evt, sec_evt, any_press, rep_en, time_zero, timeout;

  assign ss_press  = btn_start_stop & ~ss_q;
  assign rs_press  = btn_reset & ~rs_q;
  assign rep_en    = (state_q == IDLE) || (state_q == SET) || (state_q == PAUSE);
  assign time_zero = (minutes == 6'd0) && (seconds == 6'd0);
  assign timeout   = tick_1k && (alarm_cnt_q == AW'(ALARM_TIMEOUT_MS - 1));

  btn_repeat #(.DELAY(REPEAT_DELAY_MS), .RATE(REPEAT_RATE_MS)) u_rep_min (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(btn_min), .tick_i(tick_1k),
    .rep_en_i(rep_en), .press_o(min_press), .repeat_o(min_rep)
  );

  // With both held, the minute button owns auto-repeat.
  btn_repeat #(.DELAY(REPEAT_DELAY_MS), .RATE(REPEAT_RATE_MS)) u_rep_sec (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(btn_sec), .tick_i(tick_1k),
    .rep_en_i(rep_en & ~btn_min), .press_o(sec_press), .repeat_o(sec_rep)
  );

  assign min_evt   = min_press | min_rep;
  assign sec_evt   = sec_press | sec_rep;
  assign any_press = ss_press | rs_press | min_press | sec_press;

  // Priority reset > start_stop > min > sec; the winner decides even if
  // the current mode ignores it, so lower presses are dropped.
  always_comb begin
    state_d     = state_q;
    cmd_d       = CMD_NONE;
    alarm_cnt_d = '0;
    case (state_q)
      IDLE: begin
        if (rs_press)      cmd_d = CMD_RESET;
        else if (ss_press) cmd_d = CMD_NONE;
        else if (min_evt)  begin cmd_d = CMD_MIN; state_d = SET; end
        else if (sec_evt)  begin cmd_d = CMD_SEC; state_d = SET; end
      end
      SET: begin
        if (rs_press) begin
          cmd_d = CMD_RESET; state_d = IDLE;
        end else if (ss_press) begin
          if (!time_zero) begin cmd_d = CMD_START; state_d = RUN; end
        end else if (min_evt) cmd_d = CMD_MIN;
        else if (sec_evt)     cmd_d = CMD_SEC;
      end
      RUN: begin
        if (rs_press)                begin cmd_d = CMD_RESET; state_d = IDLE;  end
        else if (ss_press)           begin cmd_d = CMD_STOP;  state_d = PAUSE; end
        else if (blink || time_zero) state_d = ALARM;
      end
      PAUSE: begin
        if (rs_press)      begin cmd_d = CMD_RESET; state_d = IDLE; end
        else if (ss_press) begin cmd_d = CMD_START; state_d = RUN;  end
        else if (min_evt)  begin cmd_d = CMD_MIN;   state_d = SET;  end
        else if (sec_evt)  begin cmd_d = CMD_SEC;   state_d = SET;  end
      end
      ALARM: begin
        if (any_press || timeout) begin
          cmd_d = CMD_RESET; state_d = IDLE;
        end else begin
          alarm_cnt_d = tick_1k ? alarm_cnt_q + 1'b1 : alarm_cnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alarm_cnt_q <= '0;
      ss_q        <= 1'b1;
      rs_q        <= 1'b1;
      en_q        <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      reset_q     <= 1'b0;
      inc_min_q   <= 1'b0;
      inc_sec_q   <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      alarm_cnt_q <= alarm_cnt_d;
      ss_q        <= btn_start_stop;
      rs_q        <= btn_reset;
      en_q        <= 1'b1;
      start_q     <= (cmd_d == CMD_START);
      stop_q      <= (cmd_d == CMD_STOP);
      reset_q     <= (cmd_d == CMD_RESET);
      inc_min_q   <= (cmd_d == CMD_MIN);
      inc_sec_q   <= (cmd_d == CMD_SEC);
      alarm_q     <= (state_d == ALARM);
    end
  end

  assign en      = en_q;
  assign start   = start_q;
  assign stop    = stop_q;
  assign reset   = reset_q;
  assign inc_min = inc_min_q;
  assign inc_sec = inc_sec_q;
  assign alarm   = alarm_q;
  assign state   = state_q;

endmodule

// File: tb/tb_timer_ctrl_fsm.sv
module tb_timer_ctrl_fsm;

  localparam int DLY  = 5;
  localparam int RATE = 2;
  localparam int TMO  = 20;
  localparam int S_IDLE = 0, S_SET = 1, S_RUN = 2, S_PAUSE = 3, S_ALARM = 4;

  logic       clk = 1'b0, rst_n = 1'b0, tick_1k = 1'b0;
  logic       btn_start_stop = 1'b0, btn_reset = 1'b0, btn_min = 1'b0, btn_sec = 1'b0;
  logic [5:0] minutes = 6'd0, seconds = 6'd0;
  logic       blink = 1'b0;
  logic       en, start, stop, reset, inc_min, inc_sec, alarm;
  logic [2:0] state;

  int n_checks = 0, n_fail = 0;
  int cnt_start = 0, cnt_stop = 0, cnt_reset = 0, cnt_min = 0, cnt_sec = 0;
  int multi_cmd = 0;
  int tick_div = 0;
  bit force_zero = 1'b0;

  // ---------------- clock / tick ----------------
  always #5 clk = ~clk;

  always @(negedge clk) begin
    tick_div = (tick_div == 9) ? 0 : tick_div + 1;
    tick_1k  = (tick_div == 9);
  end

  timer_ctrl_fsm #(
    .REPEAT_DELAY_MS(DLY), .REPEAT_RATE_MS(RATE), .ALARM_TIMEOUT_MS(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_1k(tick_1k),
    .btn_start_stop(btn_start_stop), .btn_reset(btn_reset),
    .btn_min(btn_min), .btn_sec(btn_sec),
    .minutes(minutes), .seconds(seconds), .blink(blink),
    .en(en), .start(start), .stop(stop), .reset(reset),
    .inc_min(inc_min), .inc_sec(inc_sec), .alarm(alarm), .state(state)
  );

  // ---------------- pulse monitor + simple timer stand-in ----------------
  always @(negedge clk) begin
    if (int'(start) + int'(stop) + int'(reset) + int'(inc_min) + int'(inc_sec) > 1)
      multi_cmd++;
    cnt_start += int'(start);
    cnt_stop  += int'(stop);
    cnt_reset += int'(reset);
    cnt_min   += int'(inc_min);
    cnt_sec   += int'(inc_sec);
    if (reset) begin
      minutes = 6'd0;
      seconds = 6'd0;
    end else begin
      if (inc_min) minutes = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
      if (inc_sec) seconds = (seconds == 6'd59) ? 6'd0 : seconds + 6'd1;
    end
    if (force_zero) begin
      minutes = 6'd0;
      seconds = 6'd0;
    end
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected inc pulses for a hold of h ticks: the press plus its repeats.
  function automatic int exp_inc(input int h);
    return 1 + ((h >= DLY) ? 1 + (h - DLY) / RATE : 0);
  endfunction

  // ---------------- drivers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_start_stop = v;
      1: btn_reset      = v;
      2: btn_min        = v;
      default: btn_sec  = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    step(2);
    set_btn(b, 1'b0);
    step(2);
  endtask

  // Hold the given buttons for exactly h ticks seen by the DUT, then release.
  task automatic hold_ticks(input bit do_min, input bit do_sec, input int h);
    int n;
    n = 0;
    if (do_min) btn_min = 1'b1;
    if (do_sec) btn_sec = 1'b1;
    while (n < h) begin
      @(posedge clk);
      if (tick_1k) n++;
    end
    step(1);
    btn_min = 1'b0;
    btn_sec = 1'b0;
    step(3);
  endtask

  task automatic wait_ticks(input int h);
    int n;
    n = 0;
    while (n < h) begin
      @(posedge clk);
      if (tick_1k) n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int k, h, bm, bs, br, bst, bsp, g;

    // reset hygiene: btn_min held through release
    btn_min = 1'b1;
    rst_n   = 1'b0;
    step(3);
    check_eq("rst_en", 32'(en), 0);
    check_eq("rst_state", 32'(state), S_IDLE);
    check_eq("rst_cmds", 32'(start | stop | reset | inc_min | inc_sec | alarm), 0);
    rst_n = 1'b1;
    step(1);
    check_eq("en_after_release", 32'(en), 1);
    check_eq("idle_after_release", 32'(state), S_IDLE);
    step(60);
    check_eq("held_thru_reset_no_inc", cnt_min, 0);
    btn_min = 1'b0;
    step(2);

    // start_stop ignored in IDLE
    press(0);
    check_eq("idle_ss_ignored", cnt_start, 0);
    check_eq("idle_ss_state", 32'(state), S_IDLE);

    // set-and-run
    k = $urandom_range(1, 5);
    for (int i = 0; i < k; i++) press(3);
    check_eq("set_inc_sec_count", cnt_sec, k);
    check_eq("set_seconds", 32'(seconds), k);
    check_eq("set_minutes", 32'(minutes), 0);
    check_eq("set_state", 32'(state), S_SET);
    btn_start_stop = 1'b1;
    step(1);
    check_eq("start_pulse_n1", 32'(start), 1);
    check_eq("run_state", 32'(state), S_RUN);
    step(1);
    check_eq("start_one_cycle", 32'(start), 0);
    btn_start_stop = 1'b0;
    step(2);
    check_eq("start_count", cnt_start, 1);

    // min ignored in RUN
    press(2);
    check_eq("run_min_ignored", cnt_min, 0);
    check_eq("run_min_state", 32'(state), S_RUN);

    // pause / resume
    press(0);
    check_eq("pause_stop_count", cnt_stop, 1);
    check_eq("pause_state", 32'(state), S_PAUSE);
    press(0);
    check_eq("resume_start_count", cnt_start, 2);
    check_eq("resume_state", 32'(state), S_RUN);

    // priority: reset beats start_stop
    btn_reset = 1'b1;
    btn_start_stop = 1'b1;
    step(1);
    check_eq("prio_reset", 32'(reset), 1);
    check_eq("prio_no_ss", 32'(start | stop), 0);
    check_eq("prio_state", 32'(state), S_IDLE);
    btn_reset = 1'b0;
    btn_start_stop = 1'b0;
    step(2);
    check_eq("prio_stop_count", cnt_stop, 1);
    check_eq("prio_reset_count", cnt_reset, 1);
    check_eq("prio_seconds_cleared", 32'(seconds), 0);

    // auto-repeat: fixed hold of 11 ticks, then random holds
    bm = cnt_min;
    hold_ticks(1'b1, 1'b0, 11);
    check_eq("rep11_count", cnt_min - bm, 5);
    check_eq("rep11_minutes", 32'(minutes), 5);
    check_eq("rep11_state", 32'(state), S_SET);
    for (int r = 0; r < 2; r++) begin
      h  = $urandom_range(1, 14);
      bm = cnt_min;
      hold_ticks(1'b1, 1'b0, h);
      check_eq("rep_rand_count", cnt_min - bm, exp_inc(h));
    end
    h  = $urandom_range(5, 14);
    bm = cnt_min;
    bs = cnt_sec;
    hold_ticks(1'b1, 1'b1, h);
    check_eq("both_min_count", cnt_min - bm, exp_inc(h));
    check_eq("both_sec_count", cnt_sec - bs, 0);

    // start ignored in SET when time is zero
    force_zero = 1'b1;
    step(2);
    bst = cnt_start;
    press(0);
    check_eq("tz_start_ignored", cnt_start - bst, 0);
    check_eq("tz_state_set", 32'(state), S_SET);
    force_zero = 1'b0;
    press(3);
    press(0);
    check_eq("run_again", 32'(state), S_RUN);

    // alarm by blink, timeout clear
    blink = 1'b1;
    step(1);
    check_eq("blink_alarm_state", 32'(state), S_ALARM);
    check_eq("blink_alarm_out", 32'(alarm), 1);
    blink = 1'b0;
    br = cnt_reset;
    wait_ticks(TMO - 1);
    step(1);
    check_eq("alarm_no_early_reset", cnt_reset - br, 0);
    check_eq("alarm_still_high", 32'(alarm), 1);
    wait_ticks(1);
    step(1);
    check_eq("timeout_reset_pulse", 32'(reset), 1);
    check_eq("timeout_state", 32'(state), S_IDLE);
    check_eq("timeout_alarm_low", 32'(alarm), 0);
    step(1);
    check_eq("timeout_reset_count", cnt_reset - br, 1);

    // alarm by time_zero, cleared by btn_sec press at tick 3
    press(3);
    press(0);
    force_zero = 1'b1;
    g = 0;
    while (state != 3'(S_ALARM) && g < 20) begin
      step(1);
      g++;
    end
    check_eq("tz_alarm_state", 32'(state), S_ALARM);
    force_zero = 1'b0;
    wait_ticks(3);
    step(1);
    bs = cnt_sec;
    br = cnt_reset;
    btn_sec = 1'b1;
    step(1);
    check_eq("alarm_btn_reset", 32'(reset), 1);
    check_eq("alarm_btn_no_inc", 32'(inc_sec), 0);
    check_eq("alarm_btn_state", 32'(state), S_IDLE);
    btn_sec = 1'b0;
    step(2);
    check_eq("alarm_btn_sec_count", cnt_sec - bs, 0);
    check_eq("alarm_btn_reset_count", cnt_reset - br, 1);

    // asynchronous reset in ALARM
    press(3);
    press(0);
    blink = 1'b1;
    step(1);
    blink = 1'b0;
    check_eq("pre_rst_alarm", 32'(alarm), 1);
    br  = cnt_reset;
    bsp = cnt_stop;
    rst_n = 1'b0;
    #1;
    check_eq("async_en", 32'(en), 0);
    check_eq("async_state", 32'(state), S_IDLE);
    check_eq("async_alarm", 32'(alarm), 0);
    step(3);
    check_eq("async_no_reset_pulse", cnt_reset - br, 0);
    check_eq("async_no_stop_pulse", cnt_stop - bsp, 0);
    rst_n = 1'b1;
    step(2);
    check_eq("post_async_en", 32'(en), 1);
    check_eq("post_async_state", 32'(state), S_IDLE);

    check_eq("one_cmd_per_cycle", multi_cmd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
